// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one 64-bit ALU among four requesters.
// Each operation runs IDLE -> EXEC -> RESP; illegal select codes never reach the ALU.
module alu_share_arbiter #(
  parameter int N    = 63,
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*(N+1)-1:0] req_data1,
  input  logic [NREQ*(N+1)-1:0] req_data2,
  input  logic [NREQ*4-1:0]     req_sel,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [N:0]            resp_result,
  output logic                  resp_zero,
  output logic                  resp_err,
  output logic [N:0]            alu_data1,
  output logic [N:0]            alu_data2,
  output logic [3:0]            alu_select,
  input  logic [N:0]            alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] SEL_IDLE = 4'b1111;

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] grant;
  logic [N:0] op_a;
  logic [N:0] op_b;
  logic [3:0] op_sel;
  logic       op_err;

  logic       grant_found;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic [3:0] win_sel;

  function automatic logic sel_legal(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: sel_legal = 1'b1;
      default:                                              sel_legal = 1'b0;
    endcase
  endfunction

  // First valid requester at or after the round-robin pointer wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign win_sel    = req_sel[grant_idx*4 +: 4];
  assign req_ready  = (state == IDLE && grant_found) ? (NREQ'(1) << grant_idx) : '0;
  assign resp_valid = (state == RESP) ? (NREQ'(1) << grant) : '0;
  assign busy       = (state == EXEC) || (state == RESP);

  // Operands keep their last latched value; the select is parked except during a legal EXEC.
  assign alu_data1  = op_a;
  assign alu_data2  = op_b;
  assign alu_select = (state == EXEC && !op_err) ? op_sel : SEL_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      grant       <= 2'd0;
      op_a        <= '0;
      op_b        <= '0;
      op_sel      <= SEL_IDLE;
      op_err      <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant  <= grant_idx;
            op_a   <= req_data1[grant_idx*(N+1) +: N+1];
            op_b   <= req_data2[grant_idx*(N+1) +: N+1];
            op_sel <= win_sel;
            op_err <= !sel_legal(win_sel);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (op_err) begin
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b1;
          end else begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_err    <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready can retire the response.
          if (resp_ready[grant]) begin
            ptr   <= grant + 2'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stimulus queues expected responses,
// a negedge monitor retires them whenever a response handshake is seen.
module tb_alu_share_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [255:0] req_data1 = '0;
  logic [255:0] req_data2 = '0;
  logic [15:0]  req_sel = '0;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready = 4'b1111;
  logic [63:0]  resp_result;
  logic         resp_zero;
  logic         resp_err;
  logic [63:0]  alu_data1;
  logic [63:0]  alu_data2;
  logic [3:0]   alu_select;
  logic [63:0]  alu_result;
  logic         alu_zero;
  logic         busy;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] result;
    logic        zero;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.N(63), .NREQ(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; unknown selects return a marker so leaks become visible.
  always_comb begin
    alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    case (alu_select)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      4'b0111: alu_result = alu_data2;
      4'b1100: alu_result = ~(alu_data1 | alu_data2);
      default: alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  end
  assign alu_zero = (alu_result == 64'd0);

  task automatic check_value(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expect_resp(input int idx, input logic [63:0] res, input logic zero, input logic err);
    resp_t r;
    r.valid  = 4'b0001 << idx;
    r.result = res;
    r.zero   = zero;
    r.err    = err;
    exp_q.push_back(r);
  endtask

  task automatic set_req(input int idx, input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel);
    req_data1[idx*64 +: 64] = a;
    req_data2[idx*64 +: 64] = b;
    req_sel[idx*4 +: 4]     = sel;
  endtask

  // Called at posedge+1 while IDLE; returns at posedge+1 back in IDLE.
  task automatic applyStimulus(input int idx, input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] sel, input logic [63:0] exp_res,
                               input logic exp_zero, input logic exp_err, input logic [3:0] exp_alu_sel);
    bit done;
    set_req(idx, a, b, sel);
    req_valid = 4'b0001 << idx;
    @(negedge clk);
    check_value("req_ready_grant", {60'd0, req_ready}, {60'd0, 4'b0001 << idx});
    expect_resp(idx, exp_res, exp_zero, exp_err);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check_value("alu_select_exec", {60'd0, alu_select}, {60'd0, exp_alu_sel});
    check_value("busy_exec", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_value("alu_select_resp", {60'd0, alu_select}, 64'hF);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    check_value("return_to_idle", {63'd0, done}, 64'd1);
  endtask

  // Retire one expected response per observed handshake.
  always @(negedge clk) begin
    if (!reset && |(resp_valid & resp_ready)) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_resp", {60'd0, resp_valid}, 64'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check_value("resp_valid", {60'd0, resp_valid}, {60'd0, e.valid});
        check_value("resp_result", resp_result, e.result);
        check_value("resp_zero", {63'd0, resp_zero}, {63'd0, e.zero});
        check_value("resp_err", {63'd0, resp_err}, {63'd0, e.err});
      end
    end
  end

  task automatic checkOutput_reset();
    check_value("rst_busy", {63'd0, busy}, 64'd0);
    check_value("rst_req_ready", {60'd0, req_ready}, 64'd0);
    check_value("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    check_value("rst_resp_result", resp_result, 64'd0);
    check_value("rst_resp_zero", {63'd0, resp_zero}, 64'd0);
    check_value("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check_value("rst_alu_select", {60'd0, alu_select}, 64'hF);
    check_value("rst_alu_data1", alu_data1, 64'd0);
    check_value("rst_alu_data2", alu_data2, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_resp;
    int cycles;
    #1 reset = 1'b1;
    #2 checkOutput_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(0, 64'd5, 64'd3, 4'b0010, 64'd8, 1'b0, 1'b0, 4'b0010);
    applyStimulus(2, 64'h1234, 64'h1234, 4'b0110, 64'd0, 1'b1, 1'b0, 4'b0110);
    applyStimulus(3, 64'h55, 64'h66, 4'b1111, 64'd0, 1'b0, 1'b1, 4'b1111);

    // All four requesters contend; pointer is 0, so the order is 0,1,2,3,0.
    set_req(0, 64'hF0F0, 64'hFF00, 4'b0000);
    set_req(1, 64'h0F0F, 64'hF000, 4'b0001);
    set_req(2, 64'h1, 64'hABCD, 4'b0111);
    set_req(3, 64'h0, 64'h0, 4'b1100);
    expect_resp(0, 64'hF000, 1'b0, 1'b0);
    expect_resp(1, 64'hFF0F, 1'b0, 1'b0);
    expect_resp(2, 64'hABCD, 1'b0, 1'b0);
    expect_resp(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    expect_resp(0, 64'hF000, 1'b0, 1'b0);
    req_valid = 4'b1111;
    n_resp = 0;
    cycles = 0;
    while (n_resp < 5 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (|(resp_valid & resp_ready)) n_resp++;
    end
    check_value("rr_cycles", 64'(cycles), 64'd15);
    @(posedge clk); #1;
    req_valid = '0;

    // Requester 1 wraps to zero while its response is held off; requester 0 waits.
    set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    set_req(0, 64'd4, 64'd4, 4'b0010);
    resp_ready = 4'b1101;
    req_valid = 4'b0010;
    @(negedge clk);
    check_value("bp_req_ready", {60'd0, req_ready}, 64'b0010);
    expect_resp(1, 64'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check_value("bp_alu_select", {60'd0, alu_select}, 64'b0010);
    check_value("bp_req_ready_exec", {60'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_value("bp_resp_valid", {60'd0, resp_valid}, 64'b0010);
      check_value("bp_resp_result", resp_result, 64'd0);
      check_value("bp_resp_zero", {63'd0, resp_zero}, 64'd1);
      check_value("bp_req_ready_hold", {60'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 4'b1111;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    check_value("bp_done_busy", {63'd0, busy}, 64'd0);
    check_value("bp_done_resp_valid", {60'd0, resp_valid}, 64'd0);

    // Reset during EXEC drops the operation and clears outputs without a clock edge.
    set_req(0, 64'd5, 64'd7, 4'b0010);
    req_valid = 4'b0001;
    @(negedge clk);
    check_value("mid_req_ready", {60'd0, req_ready}, 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check_value("mid_alu_data1", alu_data1, 64'd5);
    #2 reset = 1'b1;
    #1 checkOutput_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    check_value("post_rst_busy", {63'd0, busy}, 64'd0);

    applyStimulus(3, 64'd10, 64'd20, 4'b0010, 64'd30, 1'b0, 1'b0, 4'b0010);
    applyStimulus(0, 64'd9, 64'd9, 4'b0101, 64'd0, 1'b0, 1'b1, 4'b1111);

    repeat (3) @(posedge clk);
    check_value("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
